opm_read_arbiter: RTL
=====================

// Module: opm_read_arbiter
// PURPOSE
//  Shares the single output-parameter-memory (OPM) read port between two requesters: 0 = SCI readback
//  controller, 1 = debug/host inspector. Issues at most one read per cycle, pipelined; returns data to
//  the issuing requester after a fixed latency. Holds off new reads when the NN core claims the memory.
// PARAMETERS
//  D_LEN      16  width of r_data / rdata_*
//  DA_AWIDTH   8  width of base address
//  OFS_WIDTH   4  width of offset within base
//  RD_LAT      4  cycles from opm_base/opm_offset update to valid r_data (>=1)
// PORTS
//  clk         in   1          clock, all logic on rising edge
//  rst_n       in   1          asynchronous active-low reset
//  req_0/1     in   1          read request; level, held until gnt seen
//  base_0/1    in   DA_AWIDTH  requested base address
//  ofs_0/1     in   OFS_WIDTH  requested offset
//  gnt_0/1     out  1          1-cycle pulse: request accepted this cycle
//  rvalid_0/1  out  1          1-cycle pulse: rdata valid for that requester
//  rdata_0/1   out  D_LEN      read data (held between rvalid pulses)
//  opm_base    out  DA_AWIDTH  to OPM read port
//  opm_offset  out  OFS_WIDTH  to OPM read port
//  r_data      in   D_LEN      from OPM read port
//  mem_hold    in   1          NN core requests exclusive memory access
//  hold_ack    out  1          high while no reads in flight and none issued (state HALT)
// BEHAVIOUR
//  Reset: gnt_*, rvalid_*, hold_ack = 0; rdata_*, opm_base, opm_offset = 0; tag pipe cleared; rr_ptr = 0;
//   state = RUN. Reset mid-burst discards all in-flight reads; no rvalid is produced for them.
//  Issue (RUN only): if any req_i, grant one: only one requesting -> it; both -> the one != rr_ptr owner
//   of last grant (rr_ptr = last granted id; after reset requester 0 wins first tie). On grant: gnt_i = 1,
//   opm_base/opm_offset <= base_i/ofs_i (registered, same edge as gnt), tag {v=1,id=i} enters pipe.
//  Requester must drop or change req in the cycle after gnt; a req still high is a new request.
//  Return: tag pipe is RD_LAT stages; when stage RD_LAT-1 valid, rdata_id <= r_data, rvalid_id = 1 next
//   cycle, i.e. rvalid exactly RD_LAT+1 cycles after the gnt cycle. Throughput 1 read/cycle sustained.
//  Address registers hold last value when nothing issued (no glitch to 0).
//  FSM:
//   RUN   - issue per above; mem_hold=1 -> DRAIN (no grant in the cycle mem_hold is first sampled high).
//   DRAIN - no grants; in-flight reads complete normally; pipe empty -> HALT.
//   HALT  - hold_ack=1; mem_hold=0 -> RUN (hold_ack=0 same edge), grants resume next cycle.
//   mem_hold dropping during DRAIN -> RUN directly (hold_ack never asserted).
//  Simultaneous grant-to-i and return-to-i in one cycle both occur; outputs independent.
//  rr_ptr updates only on a grant; unaffected by DRAIN/HALT.
// CONFIGURATION
//  OPM_ARB_LOCK_EN defined: extra inputs lock_0/1 (1 bit). While owner rr_ptr holds lock_i=1 and req_i=1,
//   the other requester is never granted (burst lock); lock is ignored in DRAIN/HALT, and mem_hold
//   still preempts. Lock without req has no effect.
//  Not defined: no lock ports; pure round-robin as above.
// TESTING
//  Reset then req_0=1 base=8'h12 ofs=3 one cycle -> gnt_0 at cycle 1, opm_base=12/offset=3, rvalid_0 at
//   gnt+5 with rdata_0=r_data model value; rvalid_1 never pulses.
//  req_0,req_1 held continuously 8 cycles -> gnts alternate 0,1,0,1...; 8 rvalids in order, each to
//   correct requester, back-to-back cycles.
//  Issue 3 reads, assert mem_hold next cycle -> no further gnt; 3 rvalids delivered; hold_ack=1 after
//   pipe empty; drop mem_hold -> hold_ack=0, pending req granted next cycle.
//  rst_n low 1 cycle with 2 reads in flight -> all outputs 0 immediately, no rvalid after reset release.
//  OPM_ARB_LOCK_EN: lock_1=1, req_0 and req_1 held 6 cycles after 1 wins -> only gnt_1 pulses;
//   drop lock_1 -> next tie goes to requester 0.
//  RD_LAT=1 build: single read -> rvalid 2 cycles after gnt; sustained alternation still 1/cycle.

Source files
------------

// File: rtl/opm_read_arbiter.sv
// Two-requester round-robin arbiter for the OPM read port, with fixed-latency tagged returns
// and a drain/halt handshake for NN-core memory ownership. Define OPM_ARB_LOCK_EN for burst lock.
module opm_read_arbiter #(
  parameter int unsigned D_LEN     = 16,
  parameter int unsigned DA_AWIDTH = 8,
  parameter int unsigned OFS_WIDTH = 4,
  parameter int unsigned RD_LAT    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_0,
  input  logic                 req_1,
`ifdef OPM_ARB_LOCK_EN
  input  logic                 lock_0,
  input  logic                 lock_1,
`endif
  input  logic [DA_AWIDTH-1:0] base_0,
  input  logic [DA_AWIDTH-1:0] base_1,
  input  logic [OFS_WIDTH-1:0] ofs_0,
  input  logic [OFS_WIDTH-1:0] ofs_1,
  output logic                 gnt_0,
  output logic                 gnt_1,
  output logic                 rvalid_0,
  output logic                 rvalid_1,
  output logic [D_LEN-1:0]     rdata_0,
  output logic [D_LEN-1:0]     rdata_1,
  output logic [DA_AWIDTH-1:0] opm_base,
  output logic [OFS_WIDTH-1:0] opm_offset,
  input  logic [D_LEN-1:0]     r_data,
  input  logic                 mem_hold,
  output logic                 hold_ack
);

  typedef enum logic [1:0] {StRun, StDrain, StHalt} state_e;

  state_e            state;
  logic              rr_ptr;
  logic              rr_valid;  // no grant since reset: ties go to requester 0
  logic [RD_LAT-1:0] tag_v;
  logic [RD_LAT-1:0] tag_id;
  logic              gnt_any;
  logic              gnt_sel;
  logic              pipe_empty;

  // Registered gnt_* act as the pipe's entry stage, so they count as in flight.
  assign pipe_empty = !gnt_0 && !gnt_1 && (tag_v == '0);

  always_comb begin
    gnt_any = 1'b0;
    gnt_sel = 1'b0;
    if (state == StRun && !mem_hold) begin
`ifdef OPM_ARB_LOCK_EN
      if (rr_valid && (rr_ptr ? (lock_1 && req_1) : (lock_0 && req_0))) begin
        gnt_any = 1'b1;
        gnt_sel = rr_ptr;
      end else
`endif
      if (req_0 && req_1) begin
        gnt_any = 1'b1;
        gnt_sel = rr_valid ? ~rr_ptr : 1'b0;
      end else if (req_0 || req_1) begin
        gnt_any = 1'b1;
        gnt_sel = req_1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StRun;
      rr_ptr     <= 1'b0;
      rr_valid   <= 1'b0;
      tag_v      <= '0;
      tag_id     <= '0;
      gnt_0      <= 1'b0;
      gnt_1      <= 1'b0;
      rvalid_0   <= 1'b0;
      rvalid_1   <= 1'b0;
      rdata_0    <= '0;
      rdata_1    <= '0;
      opm_base   <= '0;
      opm_offset <= '0;
      hold_ack   <= 1'b0;
    end else begin
      gnt_0 <= gnt_any && !gnt_sel;
      gnt_1 <= gnt_any && gnt_sel;
      if (gnt_any) begin
        opm_base   <= gnt_sel ? base_1 : base_0;
        opm_offset <= gnt_sel ? ofs_1 : ofs_0;
        rr_ptr     <= gnt_sel;
        rr_valid   <= 1'b1;
      end

      tag_v[0]  <= gnt_0 || gnt_1;
      tag_id[0] <= gnt_1;
      for (int k = 1; k < int'(RD_LAT); k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end

      rvalid_0 <= tag_v[RD_LAT-1] && !tag_id[RD_LAT-1];
      rvalid_1 <= tag_v[RD_LAT-1] && tag_id[RD_LAT-1];
      if (tag_v[RD_LAT-1] && !tag_id[RD_LAT-1]) rdata_0 <= r_data;
      if (tag_v[RD_LAT-1] && tag_id[RD_LAT-1])  rdata_1 <= r_data;

      unique case (state)
        StRun: begin
          if (mem_hold) state <= StDrain;
        end
        StDrain: begin
          if (!mem_hold) begin
            state <= StRun;
          end else if (pipe_empty) begin
            state    <= StHalt;
            hold_ack <= 1'b1;
          end
        end
        StHalt: begin
          if (!mem_hold) begin
            state    <= StRun;
            hold_ack <= 1'b0;
          end
        end
        default: begin
          state    <= StRun;
          hold_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule
